fifo_dot_mac: RTL

Downstream consumer of a pair of operand FIFOs. It drains one element from each FIFO per cycle, multiplies the pair, and accumulates DEPTH products into a dot-product result. It sits directly after the A and B FIFOs in the minilab datapath and drives their read enables. Read data is combinational: it is valid in the same cycle that rden is high.

---
 rtl/fifo_dot_mac_pkg.sv | 14 +
 rtl/mac_unit.sv | 46 ++++
 rtl/fifo_dot_mac.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_dot_mac_pkg.sv
// Shared types and width helpers for the FIFO-fed dot-product MAC.
package mac_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_t;

   function automatic int prod_width(input int data_width);
      return 2 * data_width;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply/accumulate datapath: registered product stage feeding a wrapping accumulator.
module mac_unit
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                i_clr,
   input  logic                                i_en,
   input  logic [DATA_WIDTH-1:0]               i_a,
   input  logic [DATA_WIDTH-1:0]               i_b,
   output logic [ACC_WIDTH-1:0]                o_acc,
   output logic [prod_width(DATA_WIDTH)-1:0]   o_prod,
   output logic                                o_prod_v
);

   localparam int PW = prod_width(DATA_WIDTH);

   logic [PW-1:0]        r_prod;
   logic                 r_prod_v;
   logic [ACC_WIDTH-1:0] r_acc;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_prod   <= '0;
         r_prod_v <= 1'b0;
         r_acc    <= '0;
      end else begin
         if (i_en) begin
            r_prod <= PW'(i_a) * PW'(i_b);
         end
         r_prod_v <= i_en;
         // Product from the previous pop lands here one cycle later; wraps silently.
         if (r_prod_v) begin
            r_acc <= r_acc + ACC_WIDTH'(r_prod);
         end
      end
   end

   assign o_acc    = r_acc;
   assign o_prod   = r_prod;
   assign o_prod_v = r_prod_v;

endmodule

// File: rtl/fifo_dot_mac.sv
// Dot-product consumer for paired operand FIFOs: FSM, pop counter, rden and result.
module fifo_dot_mac
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  a_empty,
   input  logic                  b_empty,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  a_rden,
   output logic                  b_rden,
   output logic                  busy,
   output logic                  done,
   output logic [ACC_WIDTH-1:0]  result
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = prod_width(DATA_WIDTH);
   localparam logic [CW-1:0] LAST    = CW'(DEPTH);
   localparam logic [CW-1:0] LAST_M1 = CW'(DEPTH - 1);

   mac_state_t           r_state;
   mac_state_t           w_next;
   logic [CW-1:0]        r_cnt;
   logic [ACC_WIDTH-1:0] r_result;
   logic                 w_pop;
   logic                 w_clr;
   logic [ACC_WIDTH-1:0] w_acc;
   logic [PW-1:0]        w_prod;
   logic                 w_prod_v;

   // Both FIFOs pop together or not at all; rst blocks a pop in the reset cycle.
   assign w_pop = (r_state == RUN) && !a_empty && !b_empty && (r_cnt < LAST) && !rst;
   assign w_clr = (r_state == IDLE) && start;

   mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .i_en     (w_pop),
      .i_a      (a_data),
      .i_b      (b_data),
      .o_acc    (w_acc),
      .o_prod   (w_prod),
      .o_prod_v (w_prod_v)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_pop && (r_cnt == LAST_M1)) w_next = DRAIN;
         DRAIN:   w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      a_rden = w_pop;
      b_rden = w_pop;
      busy   = (r_state != IDLE);
      done   = (r_state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst || w_clr) begin
         r_cnt <= '0;
      end else if (w_pop) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // In DRAIN the last product is still in the product register, so fold it in here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
      end else if (r_state == DRAIN) begin
         r_result <= w_acc + (w_prod_v ? ACC_WIDTH'(w_prod) : '0);
      end
   end

   assign result = r_result;

endmodule
